// File: rtl/gcd_job_scheduler_pkg.sv
// Shared definitions for the GCD job scheduler: FSM state encoding and default operand width.
package gcd_job_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT    = 2'b10,
        ST_DELIVER = 2'b11
    } state_t;

    localparam int GCD_N_DEFAULT = 8;

endpackage

// File: rtl/gcd_job_scheduler_operand_fifo.sv
// Operand-pair FIFO for the GCD job scheduler (module gcd_operand_fifo).
// Registered storage with a combinational read of the head entry.
module gcd_operand_fifo
    import gcd_job_scheduler_pkg::*;
#(
    parameter int N     = GCD_N_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din_p,
    input  logic [N-1:0] din_q,
    output logic [N-1:0] dout_p,
    output logic [N-1:0] dout_q,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem_p [DEPTH];
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout_p  = mem_p[rd_ptr];
    assign dout_q  = mem_q[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_p[wr_ptr] <= din_p;
            mem_q[wr_ptr] <= din_q;
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// GCD job scheduler: buffers operand pairs, issues them to the calculator, returns results.
// Optional watchdog in WAIT enabled by defining GCD_TIMEOUT_EN.
//   state      | meaning
//   ST_IDLE    | pop head; zero operand -> DELIVER locally, else load calc_p/q
//   ST_ISSUE   | one-cycle calc_start, arm guard
//   ST_WAIT    | await post-guard calc_valid (or watchdog expiry)
//   ST_DELIVER | hold out_r/out_err with out_valid until out_ready
module gcd_job_scheduler
    import gcd_job_scheduler_pkg::*;
#(
    parameter int N              = GCD_N_DEFAULT,
    parameter int DEPTH          = 4,
    parameter int GUARD          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_p,
    input  logic [N-1:0] in_q,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] calc_p,
    output logic [N-1:0] calc_q,
    output logic         calc_start,
    input  logic [N-1:0] calc_r,
    input  logic         calc_valid,
    output logic [N-1:0] out_r,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   state_y
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  fifo_p;
    logic [N-1:0]  fifo_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          head_zero;
    logic [GW-1:0] guard_cnt;
    logic          guard_done;
    logic          capture;
    logic          timeout;

    assign in_ready   = ~fifo_full;
    assign push       = in_valid & ~fifo_full;
    assign head_zero  = (fifo_p == '0) || (fifo_q == '0);
    assign guard_done = (guard_cnt == '0);
    assign capture    = (state == ST_WAIT) && guard_done && calc_valid;

    gcd_operand_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din_p  (in_p),
        .din_q  (in_q),
        .dout_p (fifo_p),
        .dout_q (fifo_q),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = head_zero ? ST_DELIVER : ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT:    if (capture || timeout) state_nxt = ST_DELIVER;
            ST_DELIVER: if (out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop        = (state == ST_IDLE) && !fifo_empty;
        calc_start = (state == ST_ISSUE);
        out_valid  = (state == ST_DELIVER);
        state_y    = state;
    end

    // Guard is a down-counter: a stale calc_valid left over from an abandoned job is masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_p    <= '0;
            calc_q    <= '0;
            out_r     <= '0;
            guard_cnt <= '0;
        end else begin
            if (pop) begin
                if (head_zero) out_r <= fifo_p | fifo_q;
                else begin
                    calc_p <= fifo_p;
                    calc_q <= fifo_q;
                end
            end
            if (state == ST_ISSUE)
                guard_cnt <= GW'(GUARD);
            else if (state == ST_WAIT && !guard_done)
                guard_cnt <= guard_cnt - GW'(1);
            if (capture)
                out_r <= calc_r;
            else if (timeout)
                out_r <= '0;
        end
    end

`ifdef GCD_TIMEOUT_EN
    localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;

    // A result arriving on the expiry cycle wins over the timeout.
    assign timeout = (state == ST_WAIT) && (wd_cnt == '0) && !capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            out_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE)
                wd_cnt <= WD_LOAD;
            else if (state == ST_WAIT && wd_cnt != '0)
                wd_cnt <= wd_cnt - 16'd1;
            if (pop || capture)
                out_err <= 1'b0;
            else if (timeout)
                out_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign out_err    = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler; the watchdog scenario runs only with GCD_TIMEOUT_EN.
module tb_gcd_job_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_p;
    logic [7:0] in_q;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] calc_p;
    logic [7:0] calc_q;
    logic       calc_start;
    logic [7:0] calc_r;
    logic       calc_valid;
    logic [7:0] out_r;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] state_y;

    int errors = 0;
    int checks = 0;

    gcd_job_scheduler #(
        .N              (8),
        .DEPTH          (4),
        .GUARD          (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_p       (in_p),
        .in_q       (in_q),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .calc_p     (calc_p),
        .calc_q     (calc_q),
        .calc_start (calc_start),
        .calc_r     (calc_r),
        .calc_valid (calc_valid),
        .out_r      (out_r),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_y    (state_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; a request accepted on this edge is withdrawn by the source.
    task automatic tick();
        logic fire;
        fire = in_valid & in_ready;
        @(posedge clk);
        #1;
        if (fire) in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] p, input logic [7:0] q);
        in_p     = p;
        in_q     = q;
        in_valid = 1'b1;
        for (int i = 0; i < 32 && in_valid; i++) tick();
        chk("push_accepted", {31'd0, in_valid}, 32'd0);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 64 && !calc_start; i++) tick();
        chk("start_seen", {31'd0, calc_start}, 32'd1);
    endtask

    // Calculator answers on the first cycle after the guard window.
    task automatic run_job(input logic [7:0] ep, input logic [7:0] eq, input logic [7:0] er);
        wait_start();
        chk("job_calc_p", {24'd0, calc_p}, {24'd0, ep});
        chk("job_calc_q", {24'd0, calc_q}, {24'd0, eq});
        tick();
        tick();
        tick();
        calc_r     = er;
        calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        calc_r     = 8'd0;
        chk("job_out_valid", {31'd0, out_valid}, 32'd1);
        chk("job_out_r", {24'd0, out_r}, {24'd0, er});
        chk("job_out_err", {31'd0, out_err}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("job_released", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen_start;
        int seen_valid;

        rst        = 1'b1;
        in_p       = 8'd0;
        in_q       = 8'd0;
        in_valid   = 1'b0;
        calc_r     = 8'd0;
        calc_valid = 1'b0;
        out_ready  = 1'b0;

        #7;
        chk("rst_state", {30'd0, state_y}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_calc_start", {31'd0, calc_start}, 32'd0);
        chk("rst_calc_p", {24'd0, calc_p}, 32'd0);
        chk("rst_out_r", {24'd0, out_r}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        #5 rst = 1'b0;
        tick();

        // gcd(48,18) through the calculator, walking every state
        in_p     = 8'd48;
        in_q     = 8'd18;
        in_valid = 1'b1;
        tick();
        chk("t1_idle", {30'd0, state_y}, 32'd0);
        chk("t1_no_start_yet", {31'd0, calc_start}, 32'd0);
        tick();
        chk("t1_issue", {30'd0, state_y}, 32'd1);
        chk("t1_start", {31'd0, calc_start}, 32'd1);
        chk("t1_calc_p", {24'd0, calc_p}, 32'd48);
        chk("t1_calc_q", {24'd0, calc_q}, 32'd18);
        tick();
        chk("t1_wait", {30'd0, state_y}, 32'd2);
        chk("t1_start_pulse", {31'd0, calc_start}, 32'd0);
        tick();
        tick();
        calc_r     = 8'd6;
        calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        calc_r     = 8'd0;
        chk("t1_deliver", {30'd0, state_y}, 32'd3);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_r", {24'd0, out_r}, 32'd6);
        tick();
        tick();
        chk("t1_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_hold_r", {24'd0, out_r}, 32'd6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_back_idle", {30'd0, state_y}, 32'd0);
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);

        // zero operands bypass the calculator
        in_p     = 8'd0;
        in_q     = 8'd35;
        in_valid = 1'b1;
        tick();
        chk("t2a_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t2a_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t2a_out_r", {24'd0, out_r}, 32'd35);
        chk("t2a_no_start", {31'd0, calc_start}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_p     = 8'd0;
        in_q     = 8'd0;
        in_valid = 1'b1;
        tick();
        chk("t2b_no_start_1", {31'd0, calc_start}, 32'd0);
        tick();
        chk("t2b_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t2b_out_r", {24'd0, out_r}, 32'd0);
        chk("t2b_no_start_2", {31'd0, calc_start}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // stale calc_valid held high across the guard window
        in_p     = 8'd21;
        in_q     = 8'd14;
        in_valid = 1'b1;
        tick();
        calc_r     = 8'd99;
        calc_valid = 1'b1;
        tick();
        chk("t4_start", {31'd0, calc_start}, 32'd1);
        tick();
        chk("t4_guard_1", {30'd0, state_y}, 32'd2);
        tick();
        chk("t4_guard_2", {30'd0, state_y}, 32'd2);
        tick();
        chk("t4_guard_end", {30'd0, state_y}, 32'd2);
        calc_r = 8'd7;
        tick();
        calc_valid = 1'b0;
        calc_r     = 8'd0;
        chk("t4_deliver", {31'd0, out_valid}, 32'd1);
        chk("t4_out_r", {24'd0, out_r}, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // back-to-back pushes with a stalled calculator fill the FIFO
        push(8'd12, 8'd8);
        push(8'd9, 8'd6);
        push(8'd10, 8'd15);
        push(8'd14, 8'd21);
        push(8'd27, 8'd18);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        chk("t3_first_waiting", {30'd0, state_y}, 32'd2);
        in_p     = 8'd16;
        in_q     = 8'd24;
        in_valid = 1'b1;
        tick();
        tick();
        chk("t3_still_full", {31'd0, in_ready}, 32'd0);
        chk("t3_still_wait", {30'd0, state_y}, 32'd2);
        calc_r     = 8'd4;
        calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        calc_r     = 8'd0;
        chk("t3_a_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_a_r", {24'd0, out_r}, 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_job(8'd9, 8'd6, 8'd3);
        run_job(8'd10, 8'd15, 8'd5);
        run_job(8'd14, 8'd21, 8'd7);
        run_job(8'd27, 8'd18, 8'd9);
        run_job(8'd16, 8'd24, 8'd8);
        tick();
        chk("t3_drained", {30'd0, state_y}, 32'd0);

        // reset in the middle of WAIT with another job queued
        push(8'd12, 8'd18);
        wait_start();
        tick();
        chk("t5_calc_p_before", {24'd0, calc_p}, 32'd12);
        push(8'd20, 8'd30);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_state", {30'd0, state_y}, 32'd0);
        chk("t5_rst_calc_p", {24'd0, calc_p}, 32'd0);
        chk("t5_rst_calc_q", {24'd0, calc_q}, 32'd0);
        chk("t5_rst_start", {31'd0, calc_start}, 32'd0);
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        calc_r     = 8'd6;
        calc_valid = 1'b1;
        seen_start = 0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (calc_start) seen_start++;
            if (out_valid) seen_valid++;
        end
        calc_valid = 1'b0;
        calc_r     = 8'd0;
        chk("t5_no_issue", seen_start, 32'd0);
        chk("t5_no_result", seen_valid, 32'd0);

`ifdef GCD_TIMEOUT_EN
        // calculator never answers: watchdog expires 16 cycles into WAIT
        push(8'd7, 8'd3);
        wait_start();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t6_wait_16", {30'd0, state_y}, 32'd2);
        tick();
        chk("t6_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_out_r", {24'd0, out_r}, 32'd0);
        chk("t6_out_err", {31'd0, out_err}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push(8'd8, 8'd12);
        run_job(8'd8, 8'd12, 8'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
